// File: rtl/bike_poly_rot_reader.sv
// Streams one polynomial out of a 1-cycle-latency BRAM in descending address
// order starting at start_addr and wrapping 0 -> MAX_ADDR, through a 2-entry FIFO.
module bike_poly_rot_reader #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_ADDR = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              dbg_state_o
);

   localparam int                CNT_W    = $clog2(MAX_ADDR + 2);
   localparam logic [CNT_W-1:0]  WORDS    = CNT_W'(MAX_ADDR + 1);
   localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(MAX_ADDR);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]  accept_cnt_q, accept_cnt_d;
   logic              inflight_q;
   logic [DATA_W-1:0] fifo_mem_q [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        fifo_cnt_q, fifo_cnt_d;

   logic       pop;
   logic       push;
   logic       issue;
   logic [2:0] occ_after_pop;

   // Output handshake: a word transfers in any cycle where out_valid & out_ready;
   // out_valid never drops and out_data never changes until that transfer happens.
   assign pop           = out_valid & out_ready;
   assign push          = inflight_q;
   assign occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue         = (state_q == RUN) & (issue_cnt_q != '0) & (occ_after_pop < 3'd2);

   assign busy        = (state_q == RUN);
   assign ram_re      = issue;
   assign ram_addr    = issue ? addr_q : last_addr_q;
   assign out_valid   = (fifo_cnt_q != 2'd0);
   assign out_data    = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
   assign out_last    = out_valid & (accept_cnt_q == CNT_W'(1));
   assign done        = pop & out_last;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      last_addr_d  = last_addr_q;
      issue_cnt_d  = issue_cnt_q;
      accept_cnt_d = accept_cnt_q;
      if (state_q == IDLE) begin
         if (start) begin
            state_d      = RUN;
            addr_d       = (start_addr > ADDR_TOP) ? ADDR_TOP : start_addr;
            issue_cnt_d  = WORDS;
            accept_cnt_d = WORDS;
         end
      end else begin
         if (issue) begin
            last_addr_d = addr_q;
            addr_d      = (addr_q == '0) ? ADDR_TOP : addr_q - ADDR_W'(1);
            issue_cnt_d = issue_cnt_q - CNT_W'(1);
         end
         if (pop) begin
            accept_cnt_d = accept_cnt_q - CNT_W'(1);
         end
         if (done) begin
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
      wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + 2'd1;
      end else if (pop && !push) begin
         fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
   end

   // Clearing inflight on reset drops any BRAM word still on its way in.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         last_addr_q   <= '0;
         issue_cnt_q   <= '0;
         accept_cnt_q  <= '0;
         inflight_q    <= 1'b0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         fifo_cnt_q    <= 2'd0;
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         last_addr_q  <= last_addr_d;
         issue_cnt_q  <= issue_cnt_d;
         accept_cnt_q <= accept_cnt_d;
         inflight_q   <= issue;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= ram_dout;
         end
      end
   end

endmodule

// File: doc/bike_poly_rot_reader.md
Name: bike_poly_rot_reader

Overview:
Streams one polynomial, stored as MAX_ADDR+1 words in a 1-cycle-latency BRAM, in descending address order with wrap-around. The read order is start_addr, start_addr-1, …, 0, MAX_ADDR, …, start_addr+1. It sits between the polynomial BRAM and the rotation/multiplier datapath and supplies rotated operands. Address generation is a decrementing counter loaded with start_addr that wraps 0 -> MAX_ADDR. A 2-entry output FIFO absorbs BRAM latency under consumer backpressure.

Parameters:
ADDR_W, 5, width of BRAM address and start_addr
DATA_W, 32, BRAM word width
MAX_ADDR, 16, highest valid word address; one pass reads MAX_ADDR+1 words

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a pass when idle
start_addr  in  ADDR_W  first address read; sampled on accepted start
busy  out  1  pass in progress
done  out  1  one-cycle pulse when the last word is accepted
ram_re  out  1  BRAM read enable
ram_addr  out  ADDR_W  BRAM read address
ram_dout  in  DATA_W  BRAM data, valid the cycle after ram_re
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_data  out  DATA_W  FIFO head word
out_last  out  1  head word is the final word of the pass

Behaviour:
- Reset (resetn=0 at a clk edge) values: FSM IDLE, FIFO empty, issue/accept counters 0, inflight 0.
- Reset output values: busy=0, done=0, ram_re=0, ram_addr=0, out_valid=0, out_last=0, out_data=0.
- Reset mid-pass aborts the pass immediately. No done pulse. Any data in flight from the BRAM is discarded.
- FSM has two states: IDLE and RUN.
- IDLE -> RUN on start=1. start is ignored while busy=1.
- On an accepted start:
  - addr register <= start_addr; if start_addr > MAX_ADDR, it is loaded as MAX_ADDR.
  - issue counter <= MAX_ADDR+1.
  - accept counter <= MAX_ADDR+1.
- busy=1 from the cycle after start through the done cycle inclusive.
- Issue rule (RUN): ram_re = (issue_cnt != 0) & (fifo_cnt + inflight - pop < 2).
  - pop = out_valid & out_ready.
  - This is a combinational path from out_ready to ram_re, and is permitted.
- On each issue:
  - ram_addr = current addr register.
  - The addr register then decrements; 0 wraps to MAX_ADDR.
  - issue_cnt decrements.
- inflight register <= ram_re. When inflight=1, ram_dout is written into the FIFO that cycle.
- FIFO has depth 2 and never overflows (guaranteed by the issue rule).
- Simultaneous push and pop is allowed.
- out_valid = FIFO non-empty. out_data is the FIFO head.
- out_last = out_valid & (accept_cnt == 1).
- On each pop: accept_cnt decrements.
- On a pop with out_last=1:
  - done=1 that cycle.
  - FSM -> IDLE next cycle; busy drops the next cycle.
- Latency: start at cycle 0 gives:
  - ram_re at cycle 1, addr=start_addr;
  - out_valid at cycle 3.
- Throughput: with out_ready held at 1, one word per cycle. MAX_ADDR+1 words take MAX_ADDR+1 consecutive cycles.
- Backpressure: with out_ready=0, out_valid/out_data hold stable; at most 2 words are buffered and issue stalls.
- ram_addr holds its last value when ram_re=0.
- A new start is accepted in the cycle after done.

Test Plan:
- Ordering and timing: BRAM holds data=addr, MAX_ADDR=16, start_addr=5, out_ready=1. Expect out_data 5,4,3,2,1,0,16,15,…,6, in 17 consecutive cycles starting cycle 3. out_last and done are set on word 6 only. busy falls the next cycle.
- Boundary starts: start_addr=0 -> sequence 0,16,15,…,1. start_addr=16 -> 16,15,…,0, with no wrap.
- Out-of-range start: start_addr=20 -> treated as 16; sequence 16,…,0, still 17 words.
- Backpressure: toggle out_ready pseudo-randomly with start_addr=9. Expect the exact 17-word sequence with no loss or duplication. ram_re is never asserted when FIFO+inflight would exceed 2. out_data is stable while out_valid & !out_ready.
- Start while busy: pulse start again mid-pass with a different start_addr. It is ignored and the sequence is unchanged. Back-to-back start in the cycle after done begins a new pass normally.
- Reset mid-pass: assert resetn=0 after 7 words. Next cycle expect busy=0, out_valid=0, ram_re=0, and no done. A subsequent start produces a full, correct pass.
